// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the default pattern that drives a 1101 detector downstream.
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out right-shift register; q_lsb presents the next bit
// to be transmitted.
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_lsb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_lsb = sr_q[0];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern LSB first for
// a programmable number of frames, with optional idle gaps between frames.
module serial_pattern_tx
    import serial_pattern_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int REPEAT_W   = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    pattern_in,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    output logic                out_bit,
    output logic                out_valid,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    function automatic logic [REPEAT_W-1:0] frames_of(input logic [REPEAT_W-1:0] r);
        return (r == '0) ? REPEAT_W'(1) : r;
    endfunction

    state_t              state_q,     state_d;
    logic [WIDTH-1:0]    pattern_q,   pattern_d;
    logic [REPEAT_W-1:0] frame_q,     frame_d;
    logic [IDX_W-1:0]    bit_idx_q,   bit_idx_d;
    logic [GAP_W-1:0]    gap_q,       gap_d;
    logic                out_bit_q,   out_bit_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    logic                piso_load;
    logic                piso_shift;
    logic [WIDTH-1:0]    piso_d;
    logic                piso_lsb;

    // bit 0 goes straight to the output flop, so the shifter is loaded with
    // the remaining bits and its LSB is always the bit due next cycle
    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (piso_load),
        .shift (piso_shift),
        .d     (piso_d),
        .q_lsb (piso_lsb)
    );

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        frame_d     = frame_q;
        bit_idx_d   = bit_idx_q;
        gap_d       = gap_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        piso_load   = 1'b0;
        piso_shift  = 1'b0;
        piso_d      = {1'b0, pattern_q[WIDTH-1:1]};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = SHIFT;
                    pattern_d   = pattern_in;
                    frame_d     = frames_of(repeat_cnt);
                    bit_idx_d   = '0;
                    out_bit_d   = pattern_in[0];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    piso_load   = 1'b1;
                    piso_d      = {1'b0, pattern_in[WIDTH-1:1]};
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (bit_idx_q != BIT_LAST) begin
                    bit_idx_d   = bit_idx_q + 1'b1;
                    out_bit_d   = piso_lsb;
                    out_valid_d = 1'b1;
                    piso_shift  = 1'b1;
                end else if (frame_q > REPEAT_W'(1)) begin
                    frame_d   = frame_q - REPEAT_W'(1);
                    bit_idx_d = '0;
                    if (GAP_CYCLES == 0) begin
                        out_bit_d   = pattern_q[0];
                        out_valid_d = 1'b1;
                        piso_load   = 1'b1;
                    end else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d     = SHIFT;
                    out_bit_d   = pattern_q[0];
                    out_valid_d = 1'b1;
                    piso_load   = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // abort overrides everything, including a simultaneous start
        if (abort) begin
            state_d     = IDLE;
            out_bit_d   = 1'b0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            piso_load   = 1'b0;
            piso_shift  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            frame_q     <= '0;
            bit_idx_q   <= '0;
            gap_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            frame_q     <= frame_d;
            bit_idx_q   <= bit_idx_d;
            gap_q       <= gap_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one instance back-to-back (no gap), one with a
// two-cycle gap, both checked against a cycle-indexed stream model.
module tb_serial_pattern_tx;
    import serial_pattern_pkg::*;

    localparam int W  = 4;
    localparam int RW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        start;
    logic [1:0]        abort;
    logic [1:0][W-1:0] pat;
    logic [1:0][RW-1:0] rep;
    logic [1:0]        ob, ov, bz, dn;
    logic [3:0]        det0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(W), .REPEAT_W(RW), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .pattern_in(pat[0]), .repeat_cnt(rep[0]),
        .out_bit(ob[0]), .out_valid(ov[0]), .busy(bz[0]), .done(dn[0]));

    serial_pattern_tx #(.WIDTH(W), .REPEAT_W(RW), .GAP_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .pattern_in(pat[1]), .repeat_cnt(rep[1]),
        .out_bit(ob[1]), .out_valid(ov[1]), .busy(bz[1]), .done(dn[1]));

    // downstream right-shifting, MSB-insert detector on the gap-free stream
    always @(posedge clk or posedge rst) begin
        if (rst) det0 <= '0;
        else if (ov[0]) det0 <= {ob[0], det0[3:1]};
    end

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int frames(input logic [RW-1:0] r);
        return (r == 0) ? 1 : int'(r);
    endfunction

    function automatic int total_of(input int n, input int g);
        return n * W + (n - 1) * g + 1;
    endfunction

    // expected {out_valid, out_bit, busy, done} in cycle c after the start edge
    function automatic logic [3:0] model(input logic [W-1:0] p, input int n, input int g, input int c);
        int t, o;
        if (c == total_of(n, g)) return 4'b0001;
        if (c < 1 || c > total_of(n, g)) return 4'b0000;
        t = c - 1;
        o = t % (W + g);
        if (o < W) return {1'b1, p[o], 1'b1, 1'b0};
        return 4'b0010;
    endfunction

    task automatic check(input int d, input logic [3:0] exp, input string tag);
        logic [3:0] obs;
        obs = {ov[d], ob[d], bz[d], dn[d]};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d {valid,bit,busy,done} observed=%b expected=%b", tag, d, obs, exp);
        end
    endtask

    task automatic kick(input int d, input logic [W-1:0] p, input logic [RW-1:0] r);
        @(negedge clk);
        start[d] = 1'b1;
        pat[d]   = p;
        rep[d]   = r;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        pat[d]   = W'($urandom);
        rep[d]   = RW'($urandom);
    endtask

    task automatic check_span(input int d, input logic [W-1:0] p, input int n,
                              input int c0, input int c1, input string tag);
        for (int c = c0; c <= c1; c++) begin
            @(negedge clk);
            check(d, model(p, n, gap_of(d), c), tag);
        end
    endtask

    task automatic check_idle(input int d, input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check(d, 4'b0000, tag);
        end
    endtask

    initial begin
        logic [W-1:0]  p, p2;
        logic [RW-1:0] r, r2;

        rst = 1'b1; start = '0; abort = '0; pat = '0; rep = '0;
        #12;
        check(0, 4'b0000, "reset");
        check(1, 4'b0000, "reset");
        @(negedge clk);
        rst = 1'b0;

        // single frame of the default pattern, detector hit on last bit
        kick(0, DEFAULT_PATTERN, 4'd1);
        check_span(0, DEFAULT_PATTERN, 1, 1, 4, "t1_bits");
        check_span(0, DEFAULT_PATTERN, 1, 5, 7, "t1_done");
        tests++;
        assert (det0 === 4'b1101) else begin
            fails++;
            $error("FAIL t1_detector observed=%b expected=%b", det0, 4'b1101);
        end

        // three frames with two-cycle gaps
        kick(1, 4'b1101, 4'd3);
        check_span(1, 4'b1101, 3, 1, 19, "t2_gap");

        // randomized transfers on both instances
        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 2; d++) begin
                p = W'($urandom);
                r = RW'($urandom_range(0, 3));
                kick(d, p, r);
                check_span(d, p, frames(r), 1, total_of(frames(r), gap_of(d)) + 1, "rand");
            end
        end

        // start with a new pattern mid-frame must be ignored
        p = 4'b1011;
        kick(0, p, 4'd2);
        check_span(0, p, 2, 1, 1, "t3_midstart");
        start[0] = 1'b1; pat[0] = 4'b0000;
        check_span(0, p, 2, 2, 2, "t3_midstart");
        start[0] = 1'b0;
        check_span(0, p, 2, 3, total_of(2, 0) + 3, "t3_midstart");

        // abort during bit 2, together with start; abort wins
        p = 4'b0111;
        kick(0, p, 4'd2);
        check_span(0, p, 2, 1, 3, "t4_pre_abort");
        abort[0] = 1'b1; start[0] = 1'b1;
        @(posedge clk);
        #1;
        abort[0] = 1'b0; start[0] = 1'b0;
        check_idle(0, 6, "t4_abort");
        kick(0, p, 4'd1);
        check_span(0, p, 1, 1, 6, "t4_after");

        // abort during a gap
        p = 4'b1001;
        kick(1, p, 4'd2);
        check_span(1, p, 2, 1, 5, "t4_pre_abort_gap");
        abort[1] = 1'b1;
        @(posedge clk);
        #1;
        abort[1] = 1'b0;
        check_idle(1, 6, "t4_abort_gap");

        // asynchronous reset mid-frame
        p = 4'b1111;
        kick(0, p, 4'd1);
        check_span(0, p, 1, 1, 2, "t5_pre_rst");
        #1 rst = 1'b1;
        #1;
        check(0, 4'b0000, "t5_rst_async");
        check(1, 4'b0000, "t5_rst_async");
        #1 rst = 1'b0;
        kick(0, DEFAULT_PATTERN, 4'd1);
        check_span(0, DEFAULT_PATTERN, 1, 1, 6, "t5_after");

        // repeat 0 means one frame; start held through DONE chains a new transfer
        p  = 4'b0110;
        p2 = 4'b1010;
        r2 = 4'd2;
        kick(0, p, 4'd0);
        check_span(0, p, 1, 1, 4, "t6_rep0");
        start[0] = 1'b1; pat[0] = p2; rep[0] = r2;
        check_span(0, p, 1, 5, 5, "t6_done");
        @(posedge clk);
        #1;
        start[0] = 1'b0; pat[0] = W'($urandom); rep[0] = RW'($urandom);
        check_span(0, p2, 2, 1, total_of(2, 0) + 2, "t6_chain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
